read_stream_engine: RTL and testbench
=====================================

// Module: read_stream_engine
// PURPOSE
// Multi-outstanding, strided read controller for RAM-like peripherals (RREQ/RADDR out, RVALID/RDATA back, any fixed or variable latency).
// Issues LENGTH reads, buffers responses in an internal FIFO and delivers them as a valid/ready stream with LAST.
// Credit-based issue: never more reads in flight plus buffered than FIFO_DEPTH, so responses are never dropped under back-pressure.
// PARAMETERS
// DATA_WIDTH  64  read data width
// ADDR_WIDTH  32  peripheral address width
// LEN_WIDTH   32  width of LENGTH and the request/response counters
// FIFO_DEPTH  8   response buffer entries; power of 2, >=2; also the maximum number of outstanding reads
// PORTS
// CLK         in   1           clock, all logic on rising edge
// RSTN        in   1           synchronous reset, active-low
// START       in   1           start a transfer; sampled only in IDLE
// START_ADDR  in   ADDR_WIDTH  first address
// STRIDE      in   ADDR_WIDTH  address increment per request, unsigned, modulo 2^ADDR_WIDTH
// LENGTH      in   LEN_WIDTH   number of reads; 0 is legal
// ABORT       in   1           stop issuing; in-flight responses still drain
// BUSY        out  1           high from the cycle after START until DONE
// DONE        out  1           1-cycle pulse at end of transfer
// ABORTED     out  1           valid with DONE: transfer ended by ABORT
// ERR         out  1           sticky: RVALID seen with no read outstanding; cleared by START
// REQ_COUNT   out  LEN_WIDTH   requests issued in this transfer
// RSP_COUNT   out  LEN_WIDTH   responses received in this transfer
// RREQ        out  1           read request, registered
// RADDR       out  ADDR_WIDTH  read address, valid with RREQ
// RVALID      in   1           read response strobe
// RDATA       in   DATA_WIDTH  read response data
// M_VALID     out  1           output stream valid
// M_DATA      out  DATA_WIDTH  output stream data
// M_LAST      out  1           marks the final element delivered in this transfer
// M_READY     in   1           output stream ready
// BEHAVIOUR
// Reset: state IDLE; all outputs 0; counters, FIFO and LEN_WIDTH registers cleared. Reset mid-transfer discards everything, with no DONE pulse.
// FSM states: IDLE, ISSUE, DRAIN, FINISH.
// - IDLE: on START, latch LENGTH, STRIDE and START_ADDR; clear the counters and ERR.
//   - LENGTH==0 goes to FINISH.
//   - Otherwise go to ISSUE. The first RREQ appears the cycle after START (latency 1).
// - ISSUE: RREQ=1 when REQ_COUNT<LEN and credit>0.
//   - credit = FIFO_DEPTH - fifo_count - (REQ_COUNT-RSP_COUNT).
//   - RADDR of request k = START_ADDR + k*STRIDE, wrapping.
//   - Go to DRAIN once REQ_COUNT==LEN, or on ABORT (no further RREQ after the ABORT cycle).
// - DRAIN: no requests. Go to FINISH when RSP_COUNT==REQ_COUNT and the FIFO is empty and not being written.
// - FINISH: DONE=1 for one cycle; ABORTED set if ABORT caused the exit; BUSY falls; return to IDLE.
// START outside IDLE is ignored. ABORT in IDLE, DRAIN or FINISH has no effect.
// Response FIFO:
// - RVALID with an outstanding read is written the same cycle.
// - FIFO output is first-word-fall-through: M_VALID rises the cycle after the write.
// - Simultaneous write and read at full or empty are both legal; count is unchanged.
// Unexpected RVALID: RVALID with REQ_COUNT==RSP_COUNT (including in IDLE) sets ERR. Its data is dropped and RSP_COUNT does not count it.
// M_LAST asserts on the element with delivered index REQ_COUNT-1 (final REQ_COUNT), whether the transfer ended normally or by abort.
// Stream handshake: M_DATA and M_LAST hold stable while M_VALID && !M_READY.
// Counters are LEN_WIDTH wide and do not wrap, because LEN <= 2^LEN_WIDTH-1.
// TESTING
// 1. START_ADDR=0x100, STRIDE=4, LENGTH=5, 1-cycle peripheral, M_READY=1 -> RADDR 0x100,0x104..0x110; 5 beats, M_LAST on 5th; DONE once, ABORTED=0.
// 2. LENGTH=20, FIFO_DEPTH=8, M_READY=0 -> exactly 8 RREQ, then stall. Release M_READY -> all 20 delivered in order, no loss.
// 3. Random 1-6 cycle response latency, random M_READY, LENGTH=100 -> data matches memory model; in-flight plus buffered never exceeds 8.
// 4. LENGTH=0 -> no RREQ; DONE pulses 2 cycles after START; M_VALID stays 0.
// 5. LENGTH=50, ABORT after 10 RREQ -> no further RREQ; the 10 responses delivered with M_LAST on the 10th; DONE with ABORTED=1.
// 6. RVALID in IDLE -> ERR=1, no M_VALID. RSTN low mid-transfer -> all outputs 0 next cycle, no DONE.

Source files
------------

// File: rtl/read_stream_engine.sv
// rtl/read_stream_engine.sv - credit-limited strided read issuer with FWFT response buffer and output stream
module read_stream_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] START_ADDR,
  input  logic [ADDR_WIDTH-1:0] STRIDE,
  input  logic [LEN_WIDTH-1:0]  LENGTH,
  input  logic                  ABORT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ABORTED,
  output logic                  ERR,
  output logic [LEN_WIDTH-1:0]  REQ_COUNT,
  output logic [LEN_WIDTH-1:0]  RSP_COUNT,
  output logic                  RREQ,
  output logic [ADDR_WIDTH-1:0] RADDR,
  input  logic                  RVALID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  output logic                  M_VALID,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_LAST,
  input  logic                  M_READY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, req_q, req_d, rsp_q, rsp_d, dlv_q, dlv_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d, next_addr_q, next_addr_d, raddr_q, raddr_d;
  logic                  rreq_q, rreq_d, err_q, err_d, abort_flag_q, abort_flag_d;
  logic                  done_q, done_d, aborted_q, aborted_d, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  start_ok, fifo_wr, fifo_rd, credit_ok;
  logic [LEN_WIDTH:0]    in_use;

  // Shared strobes: a response is only accepted while a read is outstanding, and
  // a new read is only allowed while in-flight plus buffered leaves a free slot.
  always_comb begin
    start_ok  = (state_q == IDLE) && START;
    fifo_wr   = RVALID && (req_q != rsp_q);
    fifo_rd   = (cnt_q != '0) && M_READY;
    in_use    = {1'b0, req_q - rsp_q} + (LEN_WIDTH+1)'(cnt_q);
    credit_ok = in_use < (LEN_WIDTH+1)'(FIFO_DEPTH);
  end

  // Next-state, request issue and completion signalling; a request is counted
  // in the same cycle it becomes visible on RREQ.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    stride_d     = stride_q;
    next_addr_d  = next_addr_q;
    req_d        = req_q;
    rreq_d       = 1'b0;
    raddr_d      = '0;
    abort_flag_d = abort_flag_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          len_d        = LENGTH;
          stride_d     = STRIDE;
          abort_flag_d = 1'b0;
          req_d        = '0;
          if (LENGTH == '0) begin
            state_d = FINISH;
          end else begin
            state_d     = ISSUE;
            rreq_d      = 1'b1;
            raddr_d     = START_ADDR;
            next_addr_d = START_ADDR + STRIDE;
            req_d       = LEN_WIDTH'(1);
          end
        end
      end
      ISSUE: begin
        if (req_q == len_q) begin
          state_d = DRAIN;
        end else if (ABORT) begin
          abort_flag_d = 1'b1;
          state_d      = DRAIN;
        end else if (credit_ok) begin
          rreq_d      = 1'b1;
          raddr_d     = next_addr_q;
          next_addr_d = next_addr_q + stride_q;
          req_d       = req_q + LEN_WIDTH'(1);
        end
      end
      DRAIN: begin
        if ((rsp_q == req_q) && (cnt_q == '0)) state_d = FINISH;
      end
      FINISH: begin
        done_d    = 1'b1;
        aborted_d = abort_flag_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Response buffer, response/delivery counters and the sticky stray-response flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rsp_d    = rsp_q;
    dlv_d    = dlv_q;
    err_d    = err_q;
    if (start_ok) begin
      rsp_d = '0;
      dlv_d = '0;
      err_d = 1'b0;
    end
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = RDATA;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      rsp_d           = rsp_q + LEN_WIDTH'(1);
    end else if (RVALID) begin
      err_d = 1'b1;
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      dlv_d    = dlv_q + LEN_WIDTH'(1);
    end
    cnt_d = cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
  end

  // State register; reset discards the transfer and buffer without a DONE pulse.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      len_q        <= '0;
      stride_q     <= '0;
      next_addr_q  <= '0;
      req_q        <= '0;
      rsp_q        <= '0;
      dlv_q        <= '0;
      rreq_q       <= 1'b0;
      raddr_q      <= '0;
      err_q        <= 1'b0;
      abort_flag_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      stride_q     <= stride_d;
      next_addr_q  <= next_addr_d;
      req_q        <= req_d;
      rsp_q        <= rsp_d;
      dlv_q        <= dlv_d;
      rreq_q       <= rreq_d;
      raddr_q      <= raddr_d;
      err_q        <= err_d;
      abort_flag_q <= abort_flag_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
    end
  end

  // The last element is only known once issuing has stopped (count reached or aborted).
  always_comb begin
    BUSY      = busy_q;
    DONE      = done_q;
    ABORTED   = aborted_q;
    ERR       = err_q;
    REQ_COUNT = req_q;
    RSP_COUNT = rsp_q;
    RREQ      = rreq_q;
    RADDR     = raddr_q;
    M_VALID   = (cnt_q != '0);
    M_DATA    = M_VALID ? mem_q[rd_ptr_q] : '0;
    M_LAST    = M_VALID && (dlv_q == req_q - LEN_WIDTH'(1)) &&
                ((state_q != ISSUE) || (req_q == len_q));
  end

endmodule

// File: tb/tb_read_stream_engine.sv
// tb/tb_read_stream_engine.sv - randomized self-checking bench for read_stream_engine
module tb_read_stream_engine;

  logic        CLK = 1'b0;
  logic        RSTN, START, ABORT, RVALID, M_READY;
  logic [31:0] START_ADDR, STRIDE, LENGTH, REQ_COUNT, RSP_COUNT, RADDR;
  logic [63:0] RDATA, M_DATA;
  logic        BUSY, DONE, ABORTED, ERR, RREQ, M_VALID, M_LAST;

  read_stream_engine dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .START_ADDR(START_ADDR), .STRIDE(STRIDE),
    .LENGTH(LENGTH), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED), .ERR(ERR),
    .REQ_COUNT(REQ_COUNT), .RSP_COUNT(RSP_COUNT), .RREQ(RREQ), .RADDR(RADDR),
    .RVALID(RVALID), .RDATA(RDATA), .M_VALID(M_VALID), .M_DATA(M_DATA), .M_LAST(M_LAST),
    .M_READY(M_READY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // environment state: peripheral model, stream sink and monitors
  int          cyc = 0;
  int          ready_mode = 1;   // 0 never, 1 always, 2 random
  int          lat_mode = 0;     // 0 one cycle, 1 random 1..6
  bit          stray = 0;
  logic [31:0] pq_addr[$];
  int          pq_due[$];
  logic [31:0] req_log[$];
  logic [63:0] beat_data[$];
  logic        beat_last[$];
  int          first_req_cyc, start_cyc, done_cyc;
  int          done_cnt = 0, done_base = 0;
  logic        done_aborted;
  int          rsp_drv, beats, occ, max_occ, stab_viol, mvalid_seen;
  bit          hold_pend = 0;
  logic [63:0] hold_data;
  logic        hold_last;

  function automatic logic [63:0] mem_val(input logic [31:0] a);
    return {a ^ 32'hC3C3_5A5A, a * 32'h9E37_79B1};
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [31:0] step, input int k);
    logic [31:0] kk;
    kk = k;
    return base + kk * step;
  endfunction

  initial begin : env
    int lat, due;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      RVALID = 1'b0;
      RDATA  = '0;
      if (!RSTN) begin
        pq_addr.delete();
        pq_due.delete();
        hold_pend = 0;
      end else begin
        if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
          RVALID = 1'b1;
          RDATA  = mem_val(pq_addr[0]);
          void'(pq_addr.pop_front());
          void'(pq_due.pop_front());
          rsp_drv++;
        end else if (stray) begin
          RVALID = 1'b1;
          RDATA  = {$urandom, $urandom};
          stray  = 0;
        end
        if (RREQ === 1'b1) begin
          lat = (lat_mode != 0) ? $urandom_range(1, 6) : 1;
          due = cyc + lat;
          if (pq_due.size() > 0 && due <= pq_due[$]) due = pq_due[$] + 1;
          pq_addr.push_back(RADDR);
          pq_due.push_back(due);
          req_log.push_back(RADDR);
          if (req_log.size() == 1) first_req_cyc = cyc;
        end
      end
      M_READY = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      if (M_VALID === 1'b1) mvalid_seen++;
      if (hold_pend && (M_VALID !== 1'b1 || M_DATA !== hold_data || M_LAST !== hold_last)) stab_viol++;
      hold_pend = (M_VALID === 1'b1) && !M_READY;
      hold_data = M_DATA;
      hold_last = M_LAST;
      if (M_VALID === 1'b1 && M_READY) begin
        beat_data.push_back(M_DATA);
        beat_last.push_back(M_LAST);
        beats++;
      end
      occ = pq_due.size() + rsp_drv - beats;
      if (occ > max_occ) max_occ = occ;
      if (DONE === 1'b1) begin
        done_cnt++;
        done_cyc     = cyc;
        done_aborted = ABORTED;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] s, input logic [31:0] l);
    @(posedge CLK); #2;
    req_log.delete(); beat_data.delete(); beat_last.delete();
    rsp_drv = 0; beats = 0; max_occ = 0; stab_viol = 0; mvalid_seen = 0;
    done_base = done_cnt;
    START = 1'b1; START_ADDR = a; STRIDE = s; LENGTH = l; start_cyc = cyc;
    @(posedge CLK); #2;
    START = 1'b0; START_ADDR = $urandom; STRIDE = $urandom; LENGTH = $urandom;
  endtask

  task automatic wait_done(input int budget, input int abort_after, output bit timed_out);
    int n = 0;
    bit sent = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge CLK); #2;
      ABORT = 1'b0;
      if (abort_after > 0 && !sent && req_log.size() >= abort_after) begin
        ABORT = 1'b1;
        sent  = 1;
      end
      n++;
    end
    ABORT = 1'b0;
    timed_out = (done_cnt == done_base);
  endtask

  task automatic test_reset;
    RSTN = 1'b0; START = 0; ABORT = 0; START_ADDR = 0; STRIDE = 0; LENGTH = 0;
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if ({BUSY, DONE, ABORTED, ERR, RREQ, M_VALID, M_LAST} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0", {BUSY, DONE, ABORTED, ERR, RREQ, M_VALID, M_LAST});
    end
    checks++;
    if ({REQ_COUNT, RSP_COUNT, RADDR, M_DATA} !== '0) begin
      errors++; $display("FAIL reset_values got %0h/%0h/%0h/%0h want 0", REQ_COUNT, RSP_COUNT, RADDR, M_DATA);
    end
    RSTN = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_err_idle;
    @(posedge CLK); #2;
    mvalid_seen = 0;
    stray = 1;
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL err_idle got %b want 1", ERR); end
    checks++;
    if (mvalid_seen != 0) begin errors++; $display("FAIL err_no_mvalid got %0d want 0", mvalid_seen); end
    checks++;
    if (RSP_COUNT !== 32'd0) begin errors++; $display("FAIL err_rsp_count got %0d want 0", RSP_COUNT); end
  endtask

  task automatic test_basic;
    bit to;
    ready_mode = 1; lat_mode = 0;
    start_xfer(32'h100, 32'd4, 32'd5);
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL basic_err_cleared got %b want 0", ERR); end
    wait_done(200, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout got no DONE want DONE"); end
    checks++;
    if (first_req_cyc != start_cyc + 1) begin
      errors++; $display("FAIL basic_first_req_latency got %0d want 1", first_req_cyc - start_cyc);
    end
    checks++;
    if (req_log.size() != 5) begin errors++; $display("FAIL basic_req_n got %0d want 5", req_log.size()); end
    for (int k = 0; k < req_log.size(); k++) begin
      checks++;
      if (req_log[k] !== exp_addr(32'h100, 32'd4, k)) begin
        errors++; $display("FAIL basic_addr[%0d] got %0h want %0h", k, req_log[k], exp_addr(32'h100, 32'd4, k));
      end
    end
    checks++;
    if (beat_data.size() != 5) begin errors++; $display("FAIL basic_beats got %0d want 5", beat_data.size()); end
    for (int k = 0; k < beat_data.size(); k++) begin
      checks++;
      if (beat_data[k] !== mem_val(exp_addr(32'h100, 32'd4, k)) || beat_last[k] !== (k == 4)) begin
        errors++; $display("FAIL basic_beat[%0d] got %0h/%b want %0h/%b", k, beat_data[k], beat_last[k],
                           mem_val(exp_addr(32'h100, 32'd4, k)), k == 4);
      end
    end
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (done_cnt - done_base != 1 || done_aborted !== 1'b0) begin
      errors++; $display("FAIL basic_done got %0d/%b want 1/0", done_cnt - done_base, done_aborted);
    end
  endtask

  task automatic test_backpressure;
    bit to;
    ready_mode = 0; lat_mode = 0;
    start_xfer(32'h2000, 32'd8, 32'd20);
    repeat (40) @(posedge CLK);
    #2;
    checks++;
    if (req_log.size() != 8 || REQ_COUNT !== 32'd8) begin
      errors++; $display("FAIL bp_stall got %0d/%0d want 8", req_log.size(), REQ_COUNT);
    end
    checks++;
    if (beats != 0 || BUSY !== 1'b1) begin errors++; $display("FAIL bp_hold got %0d/%b want 0/1", beats, BUSY); end
    ready_mode = 1;
    wait_done(400, 0, to);
    checks++;
    if (to || req_log.size() != 20 || beat_data.size() != 20) begin
      errors++; $display("FAIL bp_complete got %0d/%0d want 20/20", req_log.size(), beat_data.size());
    end
    for (int k = 0; k < beat_data.size(); k++) begin
      checks++;
      if (beat_data[k] !== mem_val(exp_addr(32'h2000, 32'd8, k)) || beat_last[k] !== (k == 19)) begin
        errors++; $display("FAIL bp_beat[%0d] got %0h/%b want %0h/%b", k, beat_data[k], beat_last[k],
                           mem_val(exp_addr(32'h2000, 32'd8, k)), k == 19);
      end
    end
    checks++;
    if (max_occ > 8) begin errors++; $display("FAIL bp_credit got %0d want <=8", max_occ); end
  endtask

  task automatic test_random;
    bit to;
    logic [31:0] a, s;
    a = $urandom; s = $urandom;
    ready_mode = 2; lat_mode = 1;
    start_xfer(a, s, 32'd100);
    wait_done(5000, 0, to);
    checks++;
    if (to || req_log.size() != 100 || beat_data.size() != 100) begin
      errors++; $display("FAIL rnd_complete got %0d/%0d want 100/100", req_log.size(), beat_data.size());
    end
    for (int k = 0; k < req_log.size(); k++) begin
      checks++;
      if (req_log[k] !== exp_addr(a, s, k)) begin
        errors++; $display("FAIL rnd_addr[%0d] got %0h want %0h", k, req_log[k], exp_addr(a, s, k));
      end
    end
    for (int k = 0; k < beat_data.size(); k++) begin
      checks++;
      if (beat_data[k] !== mem_val(exp_addr(a, s, k)) || beat_last[k] !== (k == 99)) begin
        errors++; $display("FAIL rnd_beat[%0d] got %0h/%b want %0h/%b", k, beat_data[k], beat_last[k],
                           mem_val(exp_addr(a, s, k)), k == 99);
      end
    end
    checks++;
    if (max_occ > 8) begin errors++; $display("FAIL rnd_credit got %0d want <=8", max_occ); end
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL rnd_stable got %0d want 0", stab_viol); end
    checks++;
    if (ERR !== 1'b0 || done_aborted !== 1'b0) begin
      errors++; $display("FAIL rnd_status got %b/%b want 0/0", ERR, done_aborted);
    end
    ready_mode = 1; lat_mode = 0;
  endtask

  task automatic test_zero_len;
    bit to;
    start_xfer(32'h40, 32'd4, 32'd0);
    wait_done(50, 0, to);
    checks++;
    if (to || done_cyc != start_cyc + 2) begin
      errors++; $display("FAIL zero_done_latency got %0d want 2", done_cyc - start_cyc);
    end
    checks++;
    if (req_log.size() != 0 || mvalid_seen != 0 || done_aborted !== 1'b0) begin
      errors++; $display("FAIL zero_activity got %0d/%0d/%b want 0/0/0", req_log.size(), mvalid_seen, done_aborted);
    end
  endtask

  task automatic test_abort;
    bit to;
    logic [31:0] s;
    s = $urandom;
    ready_mode = 1; lat_mode = 0;
    start_xfer(32'h8000, s, 32'd50);
    wait_done(500, 10, to);
    repeat (5) @(posedge CLK);
    #2;
    checks++;
    if (to || req_log.size() != 10) begin errors++; $display("FAIL abort_req_n got %0d want 10", req_log.size()); end
    checks++;
    if (REQ_COUNT !== 32'd10 || RSP_COUNT !== 32'd10) begin
      errors++; $display("FAIL abort_counts got %0d/%0d want 10/10", REQ_COUNT, RSP_COUNT);
    end
    checks++;
    if (beat_data.size() != 10) begin errors++; $display("FAIL abort_beats got %0d want 10", beat_data.size()); end
    for (int k = 0; k < beat_data.size(); k++) begin
      checks++;
      if (beat_data[k] !== mem_val(exp_addr(32'h8000, s, k)) || beat_last[k] !== (k == 9)) begin
        errors++; $display("FAIL abort_beat[%0d] got %0h/%b want %0h/%b", k, beat_data[k], beat_last[k],
                           mem_val(exp_addr(32'h8000, s, k)), k == 9);
      end
    end
    checks++;
    if (done_cnt - done_base != 1 || done_aborted !== 1'b1) begin
      errors++; $display("FAIL abort_done got %0d/%b want 1/1", done_cnt - done_base, done_aborted);
    end
  endtask

  task automatic test_reset_mid;
    ready_mode = 2; lat_mode = 1;
    start_xfer(32'h300, 32'd16, 32'd40);
    repeat (15) @(posedge CLK);
    #2;
    RSTN = 1'b0;
    @(posedge CLK); #2;
    checks++;
    if ({BUSY, DONE, ABORTED, ERR, RREQ, M_VALID, M_LAST} !== 7'b0) begin
      errors++; $display("FAIL midrst_flags got %b want 0", {BUSY, DONE, ABORTED, ERR, RREQ, M_VALID, M_LAST});
    end
    checks++;
    if ({REQ_COUNT, RSP_COUNT, RADDR, M_DATA} !== '0) begin
      errors++; $display("FAIL midrst_values got %0h/%0h/%0h/%0h want 0", REQ_COUNT, RSP_COUNT, RADDR, M_DATA);
    end
    RSTN = 1'b1;
    repeat (20) @(posedge CLK);
    #2;
    checks++;
    if (done_cnt != done_base || BUSY !== 1'b0 || ERR !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet got %0d/%b/%b want 0/0/0", done_cnt - done_base, BUSY, ERR);
    end
    ready_mode = 1; lat_mode = 0;
  endtask

  initial begin : main
    test_reset();
    test_err_idle();
    test_basic();
    test_backpressure();
    test_random();
    test_zero_len();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
